addsub_nibble_sequencer: RTL and testbench

ADDSUB_NIBBLE_SEQUENCER -- requirements
Module: addsub_nibble_sequencer

---
 rtl/addsub_nibble_sequencer.sv | 121 ++++++++++++
 tb/tb_addsub_nibble_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/addsub_nibble_sequencer.sv
// Serial add/subtract unit: one shared 4-bit slice processes the operands a
// nibble per clock, LSB first, and publishes result/cout/overflow atomically.
module addsub_nibble_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   sub,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   cout,
  output logic                   overflow
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_next;

  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic           r_sub;
  logic [CW-1:0]  r_cnt;
  logic           r_carry;
  logic [W-1:0]   r_acc;
  logic [W-1:0]   r_result;
  logic           r_cout;
  logic           r_overflow;
  logic           r_done;

  logic           w_accept;
  logic           w_last;
  logic [3:0]     w_b_nib;
  logic [4:0]     w_sum;
  logic [W-1:0]   w_acc_next;

  // Operands are shifted right after each step, so the active nibble is
  // always bits [3:0] and no variable part-select is needed.
  assign w_accept   = (r_state == S_IDLE) && start;
  assign w_last     = (r_cnt == CW'(NIBBLES - 1));
  assign w_b_nib    = r_b[3:0] ^ {4{r_sub}};
  assign w_sum      = {1'b0, r_a[3:0]} + {1'b0, w_b_nib} + {4'b0000, r_carry};
  assign w_acc_next = W'({w_sum[3:0], r_acc} >> 4);

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: default assigned first so no path through the case leaves the
  // next-state undriven, which would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_state_next = S_RUN;
      S_RUN:   if (w_last) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: every datapath register is reset; an aborted operation must leave
  // no stale carry, counter or partial sum behind for the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a        <= '0;
      r_b        <= '0;
      r_sub      <= 1'b0;
      r_cnt      <= '0;
      r_carry    <= 1'b0;
      r_acc      <= '0;
      r_result   <= '0;
      r_cout     <= 1'b0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_a     <= a;
        r_b     <= b;
        r_sub   <= sub;
        r_cnt   <= '0;
        r_carry <= sub;
      end else if (r_state == S_RUN) begin
        r_a     <= r_a >> 4;
        r_b     <= r_b >> 4;
        r_acc   <= w_acc_next;
        r_carry <= w_sum[4];
        r_cnt   <= r_cnt + CW'(1);
        if (w_last) begin
          r_result   <= w_acc_next;
          r_cout     <= w_sum[4];
          // Carry into the MSB is recovered from its sum bit: a ^ b ^ s.
          r_overflow <= r_a[3] ^ w_b_nib[3] ^ w_sum[3] ^ w_sum[4];
          r_done     <= 1'b1;
        end
      end
    end
  end

  assign busy     = (r_state == S_RUN);
  assign done     = r_done;
  assign result   = r_result;
  assign cout     = r_cout;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_addsub_nibble_sequencer.sv
// Scoreboard bench: expected results are queued when an operation is accepted
// and compared, including completion cycle, whenever done is observed.
module tb_addsub_nibble_sequencer;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;

  addsub_nibble_sequencer #(.NIBBLES(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         v;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] ai, input logic [W-1:0] bi,
                                 input logic si, input int acc_cyc);
    exp_t         e;
    logic [W-1:0] bx;
    logic [W:0]   s;
    bx    = si ? ~bi : bi;
    s     = {1'b0, ai} + {1'b0, bx} + {{W{1'b0}}, si};
    e.res = s[W-1:0];
    e.c   = s[W];
    e.v   = (ai[W-1] == bx[W-1]) && (s[W-1] != ai[W-1]);
    e.cyc = acc_cyc + N;
    return e;
  endfunction

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("result",       {16'h0, result}, {16'h0, mon_e.res});
        check("cout",         {31'h0, cout},   {31'h0, mon_e.c});
        check("overflow",     {31'h0, overflow}, {31'h0, mon_e.v});
        check("done_cycle",   cyc,             mon_e.cyc);
      end
    end
  end

  // Called just after a rising edge; returns just after the acceptance edge.
  task automatic issue(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic si);
    a     = ai;
    b     = bi;
    sub   = si;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    sb.push_back(model(ai, bi, si, cyc));
    check("busy_after_accept", {31'h0, busy}, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 32'd0);
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic         rs;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",     {31'h0, busy},     32'd0);
    check("rst_done",     {31'h0, done},     32'd0);
    check("rst_result",   {16'h0, result},   32'd0);
    check("rst_cout",     {31'h0, cout},     32'd0);
    check("rst_overflow", {31'h0, overflow}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue(16'h1234, 16'h1111, 1'b0); drain();
    issue(16'h7FFF, 16'h0001, 1'b0); drain();
    issue(16'h8000, 16'h0001, 1'b1); drain();
    issue(16'h0000, 16'h0001, 1'b1); drain();
    issue(16'hFFFF, 16'h0001, 1'b0); drain();
    repeat (3) @(posedge clk);
    #1;
    check("hold_result", {16'h0, result}, 32'h0000);
    check("hold_cout",   {31'h0, cout},   32'd1);

    for (int i = 0; i < 6; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom);
      issue(ra, rb, rs);
      drain();
    end

    // Start and operand changes while busy must be ignored.
    issue(16'h0003, 16'h0004, 1'b0);
    @(posedge clk);
    #1;
    a     = 16'hAAAA;
    b     = 16'h5555;
    sub   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_during_reject", {31'h0, busy}, 32'd1);
    drain();
    repeat (N + 2) @(posedge clk);
    #1;
    check("reject_result_hold", {16'h0, result}, 32'h0007);
    check("reject_idle",        {31'h0, busy},   32'd0);

    // Reset in the middle of an operation: immediate clear, no done pulse.
    a     = 16'h1234;
    b     = 16'h1111;
    sub   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy",     {31'h0, busy},     32'd0);
    check("abort_done",     {31'h0, done},     32'd0);
    check("abort_result",   {16'h0, result},   32'h0000);
    check("abort_cout",     {31'h0, cout},     32'd0);
    check("abort_overflow", {31'h0, overflow}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("post_abort_idle", {31'h0, busy}, 32'd0);
    issue(16'h0F0F, 16'h0101, 1'b1); drain();

    // Back-to-back with start held high; second op presented in done cycle.
    a     = 16'h0001;
    b     = 16'h0001;
    sub   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back(model(16'h0001, 16'h0001, 1'b0, cyc));
    repeat (N) @(posedge clk);
    #1;
    check("b2b_done_cycle", {31'h0, done}, 32'd1);
    a   = 16'h0005;
    b   = 16'h0002;
    sub = 1'b1;
    sb.push_back(model(16'h0005, 16'h0002, 1'b1, cyc + 1));
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_second_busy", {31'h0, busy}, 32'd1);
    drain();
    repeat (N + 2) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
